// File: rtl/m_and_pkg.sv
// ----------------------------------------------------------------------------
// m_and_pkg
// Shared constants for the m_and_gate block. The values here are the
// parameter defaults used by m_and_gate and m_and_stats.
//   M_AND_WIDTH_DEF : default operand/result width
//   M_AND_CNT_W_DEF : default width of the y_all statistics counter
// ----------------------------------------------------------------------------
package m_and_pkg;

    localparam int M_AND_WIDTH_DEF = 1;
    localparam int M_AND_CNT_W_DEF = 16;

endpackage : m_and_pkg

// File: rtl/m_and_stats.sv
// ----------------------------------------------------------------------------
// m_and_stats
// Saturating event counter. Counts rising edges of clk on which inc is high,
// stops at all-ones and never wraps. sat is registered alongside cnt so it
// rises on the same edge that cnt reaches its maximum.
//
// Ports
//   clk  in   1      rising-edge clock
//   rst  in   1      synchronous active-high reset (clears cnt and sat)
//   inc  in   1      count enable for this edge
//   cnt  out  CNT_W  current count
//   sat  out  1      high while cnt == 2^CNT_W-1
// ----------------------------------------------------------------------------
module m_and_stats
    import m_and_pkg::*;
#(
    parameter int CNT_W = M_AND_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_MAX - 1'b1;

    always_ff @(posedge clk) begin
        // Reset is tested first so it wins over a simultaneous increment.
        if (rst) begin
            cnt <= '0;
            sat <= 1'b0;
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + 1'b1;
            // sat looks ahead one step so it lands on the same edge as CNT_MAX.
            sat <= (cnt == CNT_PRE);
        end
    end

endmodule : m_and_stats

// File: rtl/m_and_gate.sv
// ----------------------------------------------------------------------------
// m_and_gate
// Bitwise AND of two operands with AND/OR reductions, a one-cycle registered
// copy of the result, and an optional counter of cycles in which every
// result bit was 1.
//
// Build option
//   M_AND_STATS_EN : when defined, builds m_and_stats to drive hi_cnt and
//                    cnt_sat. When undefined, both outputs are constant 0
//                    and no counter flops exist.
//
// Ports (declared order is significant: a, b, y may be bound positionally)
//   a        in   WIDTH  operand A
//   b        in   WIDTH  operand B
//   y        out  WIDTH  a & b, combinational
//   clk      in   1      rising-edge clock
//   rst      in   1      synchronous active-high reset
//   y_all    out  1      &y, combinational
//   y_any    out  1      |y, combinational
//   y_q      out  WIDTH  y delayed by one clk edge
//   hi_cnt   out  CNT_W  saturating count of edges with y_all == 1
//   cnt_sat  out  1      high while hi_cnt is at its maximum
// ----------------------------------------------------------------------------
module m_and_gate
    import m_and_pkg::*;
#(
    parameter int WIDTH = M_AND_WIDTH_DEF,
    parameter int CNT_W = M_AND_CNT_W_DEF
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    input  logic             clk,
    input  logic             rst,
    output logic             y_all,
    output logic             y_any,
    output logic [WIDTH-1:0] y_q,
    output logic [CNT_W-1:0] hi_cnt,
    output logic             cnt_sat
);

    // Pure combinational path: no dependence on clk or rst, and X/Z on the
    // operands propagate through & unmasked.
    assign y     = a & b;
    assign y_all = &y;
    assign y_any = |y;

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q <= '0;
        end else begin
            y_q <= y;
        end
    end

`ifdef M_AND_STATS_EN
    m_and_stats #(
        .CNT_W (CNT_W)
    ) u_stats (
        .clk (clk),
        .rst (rst),
        .inc (y_all),
        .cnt (hi_cnt),
        .sat (cnt_sat)
    );
`else
    assign hi_cnt  = '0;
    assign cnt_sat = 1'b0;
`endif

endmodule : m_and_gate

// File: tb/tb_m_and_gate.sv
// ----------------------------------------------------------------------------
// tb_m_and_gate
// Self-checking bench for m_and_gate. A WIDTH=1 instance covers the truth
// table with 1-unit steps. A WIDTH=4, CNT_W=3 instance is driven cycle by
// cycle; each applied input pushes its expected outputs into a scoreboard
// queue, and a monitor on the falling edge pops and compares.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_m_and_gate;

`ifdef M_AND_STATS_EN
    localparam bit STATS_EN = 1'b1;
`else
    localparam bit STATS_EN = 1'b0;
`endif

    localparam int CNT_MAX = 7;  // 2^3 - 1 for the CNT_W=3 instance

    typedef struct {
        logic [3:0] y;
        logic       y_all;
        logic       y_any;
        logic [3:0] y_q;
        logic [2:0] hi_cnt;
        logic       cnt_sat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // WIDTH=1 instance
    logic        a1 = 1'b0, b1 = 1'b0;
    logic        y1, y1_all, y1_any, y1_q, sat1;
    logic [15:0] cnt1;

    // WIDTH=4, CNT_W=3 instance
    logic [3:0] a = '0, b = '0;
    logic [3:0] y, y_q;
    logic       y_all, y_any, cnt_sat;
    logic [2:0] hi_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t sb[$];
    bit   done = 1'b0;

    // Reference state: what the registered outputs should hold right now.
    logic [3:0] m_yq  = '0;
    int         m_cnt = 0;

    always #5 clk = ~clk;

    m_and_gate #(.WIDTH(1)) u_dut1 (
        .a(a1), .b(b1), .y(y1), .clk(clk), .rst(rst),
        .y_all(y1_all), .y_any(y1_any), .y_q(y1_q),
        .hi_cnt(cnt1), .cnt_sat(sat1)
    );

    m_and_gate #(.WIDTH(4), .CNT_W(3)) u_dut4 (
        .a(a), .b(b), .y(y), .clk(clk), .rst(rst),
        .y_all(y_all), .y_any(y_any), .y_q(y_q),
        .hi_cnt(hi_cnt), .cnt_sat(cnt_sat)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: account for the edge that just happened using the
    // inputs that were in force before it, then apply new inputs and queue
    // what the DUT must show during this cycle.
    task automatic drive(input logic [3:0] na, input logic [3:0] nb, input logic nr);
        exp_t e;
        @(posedge clk);
        if (rst) begin
            m_yq  = '0;
            m_cnt = 0;
        end else begin
            m_yq = a & b;
            if (STATS_EN && ((a & b) == 4'hF))
                m_cnt = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
        end
        #1;
        a   = na;
        b   = nb;
        rst = nr;
        e.y       = na & nb;
        e.y_all   = ((na & nb) == 4'hF);
        e.y_any   = ((na & nb) != 4'h0);
        e.y_q     = m_yq;
        e.hi_cnt  = 3'(m_cnt);
        e.cnt_sat = (m_cnt == CNT_MAX);
        sb.push_back(e);
    endtask

    // Monitor: compares one queued expectation per falling edge.
    initial begin
        exp_t e;
        while (!done) begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("y",       32'(y),       32'(e.y));
                check("y_all",   32'(y_all),   32'(e.y_all));
                check("y_any",   32'(y_any),   32'(e.y_any));
                check("y_q",     32'(y_q),     32'(e.y_q));
                check("hi_cnt",  32'(hi_cnt),  32'(e.hi_cnt));
                check("cnt_sat", 32'(cnt_sat), 32'(e.cnt_sat));
            end
        end
    end

    // Watchdog against a stalled run.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] ra, rb;

        // Truth table on the WIDTH=1 instance, 1 time unit per step.
        for (int i = 0; i < 4; i++) begin
            logic [1:0] v;
            v  = 2'(3 - i);          // 11, 10, 01, 00
            a1 = v[1];
            b1 = v[0];
            #1;
            check("tt_y",     32'(y1),     32'(i == 0));
            check("tt_y_all", 32'(y1_all), 32'(i == 0));
            check("tt_y_any", 32'(y1_any), 32'(i == 0));
        end

        // Reset held for two edges.
        drive(4'h0, 4'h0, 1'b1);
        drive(4'h0, 4'h0, 1'b1);
        // Release; y_q follows y one edge later.
        drive(4'h1, 4'h1, 1'b0);
        drive(4'h0, 4'h1, 1'b0);
        drive(4'h1, 4'h1, 1'b0);
        // Mixed-bit pattern, then all ones.
        drive(4'b1011, 4'b0110, 1'b0);
        drive(4'hF, 4'hF, 1'b0);

        // Saturation: clear, then ten all-ones cycles.
        drive(4'h0, 4'h0, 1'b1);
        repeat (10) drive(4'hF, 4'hF, 1'b0);

        // Reset mid-count with y_all high, then resume.
        drive(4'h0, 4'h0, 1'b1);
        repeat (5) drive(4'hF, 4'hF, 1'b0);
        drive(4'hF, 4'hF, 1'b1);
        drive(4'hF, 4'hF, 1'b0);
        drive(4'hF, 4'hF, 1'b0);

        // Randomized traffic, biased toward all-ones so the counter moves.
        repeat (300) begin
            ra = 4'($urandom);
            rb = 4'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                ra = 4'hF;
                rb = 4'hF;
            end
            drive(ra, rb, ($urandom_range(0, 24) == 0));
        end

        // Let the monitor drain the last entry, bounded.
        for (int k = 0; k < 4 && sb.size() > 0; k++) @(negedge clk);
        #1;
        check("sb_drained", 32'(sb.size()), 32'd0);
        done = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_m_and_gate

// File: doc/m_and_gate.md
M_AND_GATE -- requirements
Module: m_and

Interface
REQ-001 Parameter WIDTH, default 1: bit width of operands a, b and result y.
REQ-002 Parameter CNT_W, default 16: width of the statistics counter hi_cnt.
REQ-003 Port clk  input  1  rising-edge clock; one clock domain only.
REQ-004 Port rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 Port a  input  WIDTH  operand A.
REQ-006 Port b  input  WIDTH  operand B.
REQ-007 Port y  output  WIDTH  combinational bitwise AND of a and b.
REQ-008 Port y_all  output  1  combinational AND-reduction of y.
REQ-009 Port y_any  output  1  combinational OR-reduction of y.
REQ-010 Port y_q  output  WIDTH  y registered by one clk cycle.
REQ-011 Port hi_cnt  output  CNT_W  count of cycles in which y_all was 1.
REQ-012 Port cnt_sat  output  1  high while hi_cnt holds its maximum value.
REQ-013 Declared port order shall be a, b, y, clk, rst, y_all, y_any, y_q, hi_cnt, cnt_sat, so that three-port positional instantiation (a, b, y) is legal.

Function
REQ-014 y shall equal a & b bit by bit, purely combinationally, with zero clock latency and no dependence on clk or rst.
REQ-015 y shall settle within the same simulation time step as any change on a or b; an unconnected clk or rst shall not affect y, y_all or y_any.
REQ-016 For WIDTH=1, truth table: 1,1->1; 0,1->0; 1,0->0; 0,0->0.
REQ-017 y_all = &y and y_any = |y, both combinational.
REQ-018 y_q shall take the value of y on each rising clk edge when rst is 0; latency is exactly 1 cycle.
REQ-019 hi_cnt shall increment by 1 on each rising edge on which y_all is 1 and rst is 0.
REQ-020 hi_cnt shall saturate at 2^CNT_W-1 and never wrap; cnt_sat = (hi_cnt == 2^CNT_W-1), registered with hi_cnt.
REQ-021 X or Z on a or b shall propagate per standard Verilog & semantics, with no masking.

Reset
REQ-022 When rst is 1 at a rising edge: y_q <= 0, hi_cnt <= 0, cnt_sat <= 0.
REQ-023 rst shall take priority over a simultaneous increment condition.
REQ-024 Reset asserted mid-count shall clear the count on that edge, and counting shall resume on the first edge after release.
REQ-025 rst shall not affect y, y_all or y_any.

Configuration
REQ-026 Macro M_AND_STATS_EN shall compile in the hi_cnt/cnt_sat statistics logic.
REQ-027 Without M_AND_STATS_EN, hi_cnt and cnt_sat shall be tied to constant 0, no counter flops shall be built, and all other behaviour shall be unchanged.

Structure
REQ-028 Shared package m_and_pkg shall hold the constants M_AND_WIDTH_DEF=1 and M_AND_CNT_W_DEF=16, which serve as the parameter defaults.
REQ-029 The statistics counter shall be a sub-module m_and_stats (inputs clk, rst, inc; outputs cnt, sat), instantiated only under M_AND_STATS_EN.
REQ-030 The combinational AND path shall contain no sequential elements.

Verification
REQ-031 WIDTH=1, three-port positional instantiation, apply a=1,b=1 / 0,1 / 1,0 / 0,0 with 1 time-unit steps -> y = 1,0,0,0, with y == (a & b) at every step.
REQ-032 WIDTH=4, a=4'b1011, b=4'b0110 -> y=4'b0010, y_all=0, y_any=1; then a=b=4'hF -> y=4'hF, y_all=1.
REQ-033 Hold rst=1 for 2 edges, then release; step a through 1,0 with b=1 on successive edges -> y_q=0 during reset, then follows y exactly one edge later.
REQ-034 M_AND_STATS_EN defined, CNT_W=3, a=b=1 for 10 edges -> hi_cnt counts 1..7 and then holds 7, with cnt_sat=1 from the 7th edge.
REQ-035 Counting at hi_cnt=5, assert rst for 1 edge while y_all=1 -> hi_cnt=0 after that edge, then 1 after the next edge.
REQ-036 M_AND_STATS_EN undefined, a=b=1 for 5 edges -> hi_cnt=0 and cnt_sat=0 throughout.
